// File: rtl/mul_seq_if.sv
// mul_seq_if: operand/handshake/result bundle between the control unit
// (master) and the sequential multiplier (slave).
//
// Handshake: the master raises start_in for one cycle while busy_out is low.
// The slave raises busy_out from the next cycle until the operation retires.
// It then pulses done_out for exactly one cycle, with f_out/z_out/n_out/ovf_out
// already valid in that cycle. A start_in raised while busy_out is high is dropped.
interface mul_seq_if;
  logic        start_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy_out;
  logic        done_out;
  logic [15:0] f_out;
  logic        z_out;
  logic        n_out;
  logic        ovf_out;

  modport master (
    output start_in, a_in, b_in,
    input  busy_out, done_out, f_out, z_out, n_out, ovf_out
  );

  modport slave (
    input  start_in, a_in, b_in,
    output busy_out, done_out, f_out, z_out, n_out, ovf_out
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential signed 16x16 multiplier (radix-2 shift-add on
// magnitudes, sign applied at the end). 16 CALC cycles, then FIX, then DONE.
// Optional feature macro: MYCPU_MUL_SAT_EN. When it is defined, an
// overflowing result saturates to 0x7FFF or 0x8000. When it is undefined,
// the result is the low 16 bits of the product. ovf_out is reported either way.
module mul_seq (
  input  logic         clk,
  input  logic         rst,
  mul_seq_if.slave     bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic        sign;

  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [31:0] prod;
  logic        prod_ovf;
  logic [15:0] prod_res;

  assign state_dbg = state;

  // Operand magnitudes; -32768 maps to 0x8000, which still fits unsigned.
  always_comb begin
    a_mag = bus.a_in[15] ? (~bus.a_in + 16'd1) : bus.a_in;
    b_mag = bus.b_in[15] ? (~bus.b_in + 16'd1) : bus.b_in;
  end

  // Signed product, range check and the 16-bit result to publish in FIX.
  always_comb begin
    prod     = sign ? (~acc + 32'd1) : acc;
    // Representable in 16 signed bits only if bits 31..15 are all equal.
    prod_ovf = !((prod[31:15] == 17'h00000) || (prod[31:15] == 17'h1FFFF));
`ifdef MYCPU_MUL_SAT_EN
    if (prod_ovf)
      prod_res = prod[31] ? 16'h8000 : 16'h7FFF;
    else
      prod_res = prod[15:0];
`else
    prod_res = prod[15:0];
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mcand        <= 32'd0;
      mplier       <= 16'd0;
      acc          <= 32'd0;
      cnt          <= 4'd0;
      sign         <= 1'b0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.f_out    <= 16'h0000;
      bus.z_out    <= 1'b0;
      bus.n_out    <= 1'b0;
      bus.ovf_out  <= 1'b0;
    end else begin
      bus.done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            mcand        <= {16'd0, a_mag};
            mplier       <= b_mag;
            sign         <= bus.a_in[15] ^ bus.b_in[15];
            acc          <= 32'd0;
            cnt          <= 4'd0;
            bus.busy_out <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15)
            state <= FIX;
        end
        FIX: begin
          bus.f_out    <= prod_res;
          bus.z_out    <= (prod_res == 16'h0000);
          bus.n_out    <= prod_res[15];
          bus.ovf_out  <= prod_ovf;
          bus.done_out <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          bus.busy_out <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.busy_out <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed plus random checks of mul_seq against an
// integer-arithmetic reference model of the signed product.
module tb_mul_seq;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         tests_run;
  int         fails;
  logic [18:0] exp_q[$];

  mul_seq_if bus ();

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {ovf, n, z, f} from the true signed product.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int          sa;
    int          sb;
    int          p;
    logic        ovf;
    logic [15:0] f;
    logic [31:0] pv;
    sa  = $signed(a);
    sb  = $signed(b);
    p   = sa * sb;
    pv  = p;
    ovf = (p > 32767) || (p < -32768);
`ifdef MYCPU_MUL_SAT_EN
    if (p > 32767)       f = 16'h7FFF;
    else if (p < -32768) f = 16'h8000;
    else                 f = pv[15:0];
`else
    f = pv[15:0];
`endif
    return {ovf, f[15], (f == 16'h0000), f};
  endfunction

  function automatic logic [20:0] outs();
    return {bus.busy_out, bus.done_out, bus.ovf_out, bus.n_out, bus.z_out, bus.f_out};
  endfunction

  // Driver: issue one multiply and check latency, result and retirement.
  // With disturb set, start_in is pulsed and operands are changed mid-CALC.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit disturb);
    int          lat;
    logic [18:0] exp;
    exp_q.push_back(model(a, b));
    bus.a_in     = a;
    bus.b_in     = b;
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (disturb && n == 3) begin
        bus.start_in = 1'b1;
        bus.a_in     = 16'($urandom);
        bus.b_in     = 16'($urandom);
      end
      if (disturb && n == 5) bus.start_in = 1'b0;
      if (n == 2) check("busy_during_calc", {31'd0, bus.busy_out}, 32'd1);
      if (bus.done_out) begin
        lat = n;
        break;
      end
      step();
    end
    check("done_latency", lat, 32'd18);
    exp = exp_q.pop_front();
    if (lat != 0) begin
      check("result", {13'd0, bus.ovf_out, bus.n_out, bus.z_out, bus.f_out}, {13'd0, exp});
      check("busy_at_done", {31'd0, bus.busy_out}, 32'd1);
      step();
      check("after_done", {30'd0, bus.busy_out, bus.done_out}, 32'd0);
    end
    if (disturb) begin
      for (int n = 0; n < 25; n++) begin
        check("no_second_done", {31'd0, bus.done_out}, 32'd0);
        step();
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    fails        = 0;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    bus.a_in     = 16'h0000;
    bus.b_in     = 16'h0000;
    step();
    step();
    rst = 1'b0;

    // Reset state held while idle
    for (int n = 0; n < 20; n++) begin
      check("reset_idle", {11'd0, outs()}, 32'd0);
      step();
    end

    // Directed operand patterns
    run_op(16'h0007, 16'hFFFD, 1'b0);
    run_op(16'd300,  16'd200,  1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b1);
    run_op(16'h0123, 16'hFF00, 1'b1);

    // Random operands, including small ones that stay in range
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        run_op(16'($urandom), 16'($urandom), 1'b0);
      else
        run_op(16'($signed(8'($urandom))), 16'($signed(8'($urandom))), 1'b0);
    end

    // Reset in cycle 8 of CALC
    bus.a_in     = 16'h0011;
    bus.b_in     = 16'h0022;
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
    for (int n = 1; n < 8; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_calc_reset_outs", {11'd0, outs()}, 32'd0);
    check("mid_calc_reset_state", {30'd0, state_dbg}, 32'd0);
    for (int n = 0; n < 20; n++) begin
      check("no_done_after_abort", {31'd0, bus.done_out}, 32'd0);
      step();
    end
    run_op(16'h0011, 16'h0022, 1'b0);
    run_op(16'hFFF0, 16'h0100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
